// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg: shared pipeline constants and IF/ID slot state type
package fetch_stage_pkg;
  localparam int WORD_W = 32;
  localparam int INST_BYTES = 4;
  localparam logic [WORD_W-1:0] BUBBLE_INST = 32'h0;
  typedef enum logic {EMPTY, FULL} slot_e;
endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// if_id_reg: IF/ID pipeline register with load, hold and flush
module if_id_reg
  import fetch_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              hold,
  input  logic              flush,
  input  logic [WORD_W-1:0] pc_in,
  input  logic [WORD_W-1:0] inst_in,
  output logic [WORD_W-1:0] if_pc,
  output logic [WORD_W-1:0] if_inst,
  output logic              if_valid
);
  slot_e state_q, state_d;
  logic take;
  assign take = load && !hold;
  assign if_valid = state_q == FULL;
  always_comb state_d = flush ? EMPTY : take ? FULL : state_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      if_pc <= '0;
      if_inst <= BUBBLE_INST;
    end else begin
      state_q <= state_d;
      if (flush) begin
        if_pc <= '0;
        if_inst <= BUBBLE_INST;
      end else if (take) begin
        if_pc <= pc_in;
        if_inst <= inst_in;
      end
    end
  end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC register, next-PC selection, fetch counter and IF/ID capture
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = 32'h0000_0000,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              branch_taken,
  input  logic [WORD_W-1:0] branch_addr,
  output logic [WORD_W-1:0] imem_addr,
  input  logic [WORD_W-1:0] imem_inst,
  output logic [WORD_W-1:0] if_pc,
  output logic [WORD_W-1:0] if_inst,
  output logic              if_valid,
  output logic [CNT_W-1:0]  fetch_count
);
  logic [WORD_W-1:0] pc, pc_inc;
  logic adv;
  assign pc_inc = pc + WORD_W'(INST_BYTES);
  assign adv = !branch_taken && !freeze;
  assign imem_addr = pc;
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
      fetch_count <= '0;
    end else if (branch_taken) begin
      pc <= {branch_addr[WORD_W-1:2], 2'b00};
    end else if (!freeze) begin
      pc <= pc_inc;
      fetch_count <= fetch_count + CNT_W'(!(&fetch_count));
    end
  end
  if_id_reg u_if_id (
    .clk(clk),
    .rst(rst),
    .load(adv),
    .hold(freeze),
    .flush(branch_taken),
    .pc_in(pc_inc),
    .inst_in(imem_inst),
    .if_pc(if_pc),
    .if_inst(if_inst),
    .if_valid(if_valid)
  );
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scoreboard bench for fetch_stage incl. wrap and saturation variants
module tb_fetch_stage;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] ipc;
    logic [31:0] inst;
    logic        v;
    logic [15:0] cnt;
  } exp_t;
  logic clk = 0, rst = 0, freeze = 0, branch_taken = 0;
  logic [31:0] branch_addr = 0;
  logic [31:0] imem_addr, imem_inst, if_pc, if_inst;
  logic if_valid;
  logic [15:0] fetch_count;
  logic zero = 0;
  logic [31:0] zaddr = 0;
  logic [31:0] h_addr, h_inst, h_pc, h_iinst;
  logic h_valid;
  logic [15:0] h_cnt;
  logic [31:0] c_addr, c_inst, c_pc, c_iinst;
  logic c_valid;
  logic [3:0] c_cnt;
  int total = 0, bad = 0;
  exp_t q[$];
  logic [31:0] m_pc, m_ipc, m_inst;
  logic m_v;
  logic [15:0] m_cnt;
  logic [3:0] m_c;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, ~a[15:0]};
  endfunction

  assign imem_inst = mem(imem_addr);
  assign h_inst = mem(h_addr);
  assign c_inst = mem(c_addr);

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .rst(rst), .freeze(freeze), .branch_taken(branch_taken),
    .branch_addr(branch_addr), .imem_addr(imem_addr), .imem_inst(imem_inst),
    .if_pc(if_pc), .if_inst(if_inst), .if_valid(if_valid), .fetch_count(fetch_count)
  );
  fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_h (
    .clk(clk), .rst(rst), .freeze(zero), .branch_taken(zero),
    .branch_addr(zaddr), .imem_addr(h_addr), .imem_inst(h_inst),
    .if_pc(h_pc), .if_inst(h_iinst), .if_valid(h_valid), .fetch_count(h_cnt)
  );
  fetch_stage #(.CNT_W(4)) dut_c (
    .clk(clk), .rst(rst), .freeze(zero), .branch_taken(zero),
    .branch_addr(zaddr), .imem_addr(c_addr), .imem_inst(c_inst),
    .if_pc(c_pc), .if_inst(c_iinst), .if_valid(c_valid), .fetch_count(c_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input logic r, input logic f, input logic b, input logic [31:0] ba);
    exp_t e;
    rst = r;
    freeze = f;
    branch_taken = b;
    branch_addr = ba;
    if (r) begin
      m_pc = 32'h0; m_ipc = 0; m_inst = 0; m_v = 0; m_cnt = 0;
    end else if (b) begin
      m_pc = {ba[31:2], 2'b00}; m_ipc = 0; m_inst = 0; m_v = 0;
    end else if (!f) begin
      m_ipc = m_pc + 4;
      m_inst = mem(m_pc);
      m_v = 1;
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 1;
      m_pc = m_pc + 4;
    end
    m_c = r ? 4'd0 : (m_c == 4'd15 ? 4'd15 : m_c + 4'd1);
    e.pc = m_pc; e.ipc = m_ipc; e.inst = m_inst; e.v = m_v; e.cnt = m_cnt;
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk("pc", imem_addr, e.pc);
    chk("if_pc", if_pc, e.ipc);
    chk("if_inst", if_inst, e.inst);
    chk("if_valid", {31'b0, if_valid}, {31'b0, e.v});
    chk("fetch_count", {16'b0, fetch_count}, {16'b0, e.cnt});
    chk("sat_count", {28'b0, c_cnt}, {28'b0, m_c});
  endtask

  initial begin
    m_pc = 0; m_ipc = 0; m_inst = 0; m_v = 0; m_cnt = 0; m_c = 0;
    step(1, 0, 0, 0);
    step(1, 1, 1, 32'h1234);
    chk("wrap_pc0", h_addr, 32'hFFFF_FFF8);
    step(0, 0, 0, 0);
    chk("wrap_pc1", h_addr, 32'hFFFF_FFFC);
    step(0, 0, 0, 0);
    chk("wrap_pc2", h_addr, 32'h0000_0000);
    chk("wrap_valid", {31'b0, h_valid}, 32'd1);
    repeat (3) step(0, 1, 0, 0);
    chk("frz_pc", imem_addr, 32'h8);
    step(0, 0, 0, 0);
    chk("post_frz_pc", imem_addr, 32'hC);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("pre_br_pc", imem_addr, 32'h14);
    step(0, 0, 1, 32'h0000_0043);
    chk("br_pc", imem_addr, 32'h40);
    step(0, 0, 0, 0);
    chk("br_ipc", if_pc, 32'h44);
    step(0, 1, 1, 32'h10);
    chk("brfrz_pc", imem_addr, 32'h10);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(1, 0, 1, 32'h80);
    chk("rstbr_pc", imem_addr, 32'h0);
    repeat (40) begin
      logic [31:0] u;
      u = $urandom;
      step(u[4:0] == 0, u[7:5] == 0, u[10:8] == 0, {16'h0, u[31:16]});
    end
    repeat (20) step(0, 0, 0, 0);
    chk("sat_final", {28'b0, c_cnt}, 32'd15);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
